// File: rtl/xor_hash_pkg.sv
// Shared definitions for the XOR-encoded multi-ported hash table:
// op encodings, controller states, entry field layout and the key-to-index fold.
package xor_hash_pkg;

    localparam logic OPT_INSERT = 1'b0;
    localparam logic OPT_DELETE = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Entry layout, LSB first: key, value, valid.
    localparam int KEY_LSB = 0;

    function automatic int value_lsb(input int key_width);
        return key_width;
    endfunction

    function automatic int valid_bit(input int key_width, input int value_width);
        return key_width + value_width;
    endfunction

    localparam int MAX_KEY_W  = 256;
    localparam int MAX_IDX_W  = 32;
    localparam int KEY_SEL_W  = $clog2(MAX_KEY_W);
    localparam int IDX_SEL_W  = $clog2(MAX_IDX_W);

    // Key bit i lands on index bit (i mod index_width), which XORs all chunks
    // together and leaves the top chunk implicitly zero-padded.
    function automatic logic [MAX_IDX_W-1:0] xor_fold(
        input logic [MAX_KEY_W-1:0] key,
        input int                   key_width,
        input int                   index_width
    );
        logic [MAX_IDX_W-1:0] idx;
        int                   b;
        idx = '0;
        for (int i = 0; i < MAX_KEY_W; i++) begin
            b = i % index_width;
            if (i < key_width) begin
                idx[b[IDX_SEL_W-1:0]] = idx[b[IDX_SEL_W-1:0]] ^ key[i[KEY_SEL_W-1:0]];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/xor_hash_bank.sv
// One XOR bank: a single write port (or INIT clear) mirrored into NUM_PORTS
// identical 1W1R copies, each with a registered read-first output.
module xor_hash_bank #(
    parameter int DATA_WIDTH  = 64,
    parameter int INDEX_WIDTH = 12,
    parameter int NUM_PORTS   = 12
) (
    input  logic                             clk,
    input  logic                             init_en_i,
    input  logic [INDEX_WIDTH-1:0]           init_addr_i,
    input  logic                             wr_en_i,
    input  logic [INDEX_WIDTH-1:0]           wr_addr_i,
    input  logic [DATA_WIDTH-1:0]            wr_data_i,
    input  logic [NUM_PORTS*INDEX_WIDTH-1:0] rd_addr_i,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rd_data_o
);

    localparam int DEPTH = 2**INDEX_WIDTH;

    logic                   we;
    logic [INDEX_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]  wdata;

    always_comb begin
        we    = init_en_i | wr_en_i;
        waddr = init_en_i ? init_addr_i : wr_addr_i;
        wdata = init_en_i ? '0 : wr_data_i;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_copy
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        // NOTE: the array has no reset; the controller's INIT sweep zeroes it instead.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rd_q <= mem[rd_addr_i[p*INDEX_WIDTH +: INDEX_WIDTH]];
        end

        assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

endmodule

// File: rtl/xor_hash_table_mp.sv
// XOR-encoded multi-ported direct-mapped hash table with insert/delete, same-cycle
// arbitration and write forwarding. Define XOR_HASH_READ_BYPASS_EN for read-after-write bypass.
module xor_hash_table_mp
    import xor_hash_pkg::*;
#(
    parameter int NUM_WR      = 4,
    parameter int NUM_RD      = 8,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 31,
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = KEY_WIDTH + VALUE_WIDTH + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          in_ready,
    input  logic [NUM_WR-1:0]             wr_valid,
    input  logic [NUM_WR-1:0]             wr_opt,
    input  logic [NUM_WR*KEY_WIDTH-1:0]   wr_key,
    input  logic [NUM_WR*VALUE_WIDTH-1:0] wr_value,
    output logic [NUM_WR-1:0]             wr_ack,
    output logic [NUM_WR-1:0]             wr_conflict,
    input  logic [NUM_RD-1:0]             rd_valid,
    input  logic [NUM_RD*KEY_WIDTH-1:0]   rd_key,
    output logic [NUM_RD-1:0]             rd_out_valid,
    output logic [NUM_RD-1:0]             rd_hit,
    output logic [NUM_RD*DATA_WIDTH-1:0]  rd_data
);

    localparam int DEPTH     = 2**INDEX_WIDTH;
    localparam int NUM_PORTS = NUM_WR + NUM_RD;
    localparam int VLD_BIT   = valid_bit(KEY_WIDTH, VALUE_WIDTH);
    localparam int VAL_LSB   = value_lsb(KEY_WIDTH);

    typedef logic [DATA_WIDTH-1:0]  entry_t;
    typedef logic [INDEX_WIDTH-1:0] idx_t;
    typedef logic [KEY_WIDTH-1:0]   key_t;
    typedef logic [VALUE_WIDTH-1:0] val_t;

    function automatic idx_t hash_idx(input key_t key);
        logic [MAX_KEY_W-1:0] key_ext;
        key_ext                 = '0;
        key_ext[KEY_WIDTH-1:0]  = key;
        return idx_t'(xor_fold(key_ext, KEY_WIDTH, INDEX_WIDTH));
    endfunction

    // ---------------- INIT / RUN controller ----------------
    state_e state_q, state_d;
    idx_t   cnt_q, cnt_d;
    logic   init_en;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == idx_t'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready = (state_q == ST_RUN);
    assign init_en  = (state_q == ST_INIT);

    // ---------------- S0: accept, arbitrate, forward select ----------------
    logic [NUM_WR-1:0] wr_acc, wr_conf_in, s1_we;
    idx_t              wr_idx_in [NUM_WR];
    logic [NUM_WR-1:0] wr_fwd_in [NUM_WR];
    logic [NUM_RD-1:0] rd_acc;
    idx_t              rd_idx_in [NUM_RD];
    logic [NUM_WR-1:0] rd_fwd_in [NUM_RD];
    idx_t              s1_idx_q  [NUM_WR];
    logic [NUM_PORTS*INDEX_WIDTH-1:0] bank_raddr;

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_acc[w]    = in_ready & wr_valid[w];
            wr_idx_in[w] = hash_idx(wr_key[w*KEY_WIDTH +: KEY_WIDTH]);
        end
        for (int w = 0; w < NUM_WR; w++) begin
            wr_conf_in[w] = 1'b0;
            for (int v = 0; v < w; v++) begin
                if (wr_acc[v] && (wr_idx_in[v] == wr_idx_in[w])) begin
                    wr_conf_in[w] = 1'b1;
                end
            end
            // The memory read at this edge misses any S1 write landing on the same edge.
            for (int u = 0; u < NUM_WR; u++) begin
                wr_fwd_in[w][u] = s1_we[u] && (s1_idx_q[u] == wr_idx_in[w]);
            end
        end
        for (int r = 0; r < NUM_RD; r++) begin
            rd_acc[r]    = in_ready & rd_valid[r];
            rd_idx_in[r] = hash_idx(rd_key[r*KEY_WIDTH +: KEY_WIDTH]);
`ifdef XOR_HASH_READ_BYPASS_EN
            for (int u = 0; u < NUM_WR; u++) begin
                rd_fwd_in[r][u] = s1_we[u] && (s1_idx_q[u] == rd_idx_in[r]);
            end
`else
            rd_fwd_in[r] = '0;
`endif
        end
        bank_raddr = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            bank_raddr[w*INDEX_WIDTH +: INDEX_WIDTH] = wr_idx_in[w];
        end
        for (int r = 0; r < NUM_RD; r++) begin
            bank_raddr[(NUM_WR+r)*INDEX_WIDTH +: INDEX_WIDTH] = rd_idx_in[r];
        end
    end

    // ---------------- S1 registers ----------------
    logic [NUM_WR-1:0] s1_vld_q, s1_conf_q, s1_op_q;
    logic [NUM_WR-1:0] s1_fwd_q [NUM_WR];
    key_t              s1_key_q [NUM_WR];
    val_t              s1_val_q [NUM_WR];
    entry_t            enc_q    [NUM_WR];
    entry_t            enc_d    [NUM_WR];
    logic [NUM_RD-1:0] rd_s1_vld_q;
    logic [NUM_WR-1:0] rd_fwd_q [NUM_RD];
    key_t              rd_key_q [NUM_RD];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q    <= '0;
            s1_conf_q   <= '0;
            rd_s1_vld_q <= '0;
            for (int w = 0; w < NUM_WR; w++) s1_fwd_q[w] <= '0;
            for (int r = 0; r < NUM_RD; r++) rd_fwd_q[r] <= '0;
        end else begin
            s1_vld_q    <= wr_acc;
            s1_conf_q   <= wr_conf_in;
            rd_s1_vld_q <= rd_acc;
            for (int w = 0; w < NUM_WR; w++) s1_fwd_q[w] <= wr_fwd_in[w];
            for (int r = 0; r < NUM_RD; r++) rd_fwd_q[r] <= rd_fwd_in[r];
        end
    end

    always_ff @(posedge clk) begin
        s1_op_q <= wr_opt;
        for (int w = 0; w < NUM_WR; w++) begin
            s1_key_q[w] <= wr_key[w*KEY_WIDTH +: KEY_WIDTH];
            s1_val_q[w] <= wr_value[w*VALUE_WIDTH +: VALUE_WIDTH];
            s1_idx_q[w] <= wr_idx_in[w];
            enc_q[w]    <= enc_d[w];
        end
        for (int r = 0; r < NUM_RD; r++) begin
            rd_key_q[r] <= rd_key[r*KEY_WIDTH +: KEY_WIDTH];
        end
    end

    assign s1_we = s1_vld_q & ~s1_conf_q;

    // ---------------- banks ----------------
    logic [NUM_PORTS*DATA_WIDTH-1:0] bank_rd [NUM_WR];

    for (genvar b = 0; b < NUM_WR; b++) begin : g_bank
        xor_hash_bank #(
            .DATA_WIDTH  (DATA_WIDTH),
            .INDEX_WIDTH (INDEX_WIDTH),
            .NUM_PORTS   (NUM_PORTS)
        ) u_bank (
            .clk         (clk),
            .init_en_i   (init_en),
            .init_addr_i (cnt_q),
            .wr_en_i     (s1_we[b]),
            .wr_addr_i   (s1_idx_q[b]),
            .wr_data_i   (enc_d[b]),
            .rd_addr_i   (bank_raddr),
            .rd_data_o   (bank_rd[b])
        );
    end

    // ---------------- S1: decode, update, re-encode ----------------
    always_comb begin
        entry_t cur, own, nxt, word;
        for (int w = 0; w < NUM_WR; w++) begin
            cur = '0;
            own = '0;
            for (int b = 0; b < NUM_WR; b++) begin
                word = s1_fwd_q[w][b] ? enc_q[b] : bank_rd[b][w*DATA_WIDTH +: DATA_WIDTH];
                cur  = cur ^ word;
                if (b == w) own = word;
            end
            nxt = cur;
            if (s1_op_q[w] == OPT_INSERT) begin
                nxt                              = '0;
                nxt[VLD_BIT]                     = 1'b1;
                nxt[VAL_LSB +: VALUE_WIDTH]      = s1_val_q[w];
                nxt[KEY_LSB +: KEY_WIDTH]        = s1_key_q[w];
            end
            if ((s1_op_q[w] == OPT_DELETE) && cur[VLD_BIT] &&
                (cur[KEY_LSB +: KEY_WIDTH] == s1_key_q[w])) begin
                nxt = '0;
            end
            // cur ^ own is the XOR of every other bank at this index.
            enc_d[w] = nxt ^ cur ^ own;
        end
    end

    // ---------------- read decode and output registers ----------------
    logic [NUM_RD-1:0]            rd_hit_d;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_d;

    always_comb begin
        entry_t ent;
        rd_hit_d  = '0;
        rd_data_d = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            ent = '0;
            for (int b = 0; b < NUM_WR; b++) begin
                ent = ent ^ (rd_fwd_q[r][b] ? enc_q[b]
                                            : bank_rd[b][(NUM_WR+r)*DATA_WIDTH +: DATA_WIDTH]);
            end
            rd_hit_d[r] = rd_s1_vld_q[r] && ent[VLD_BIT] &&
                          (ent[KEY_LSB +: KEY_WIDTH] == rd_key_q[r]);
            if (rd_hit_d[r]) begin
                rd_data_d[r*DATA_WIDTH +: DATA_WIDTH] = ent;
            end
        end
    end

    logic [NUM_WR-1:0]            wr_ack_q, wr_conf_q;
    logic [NUM_RD-1:0]            rd_vld_q, rd_hit_q;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ack_q  <= '0;
            wr_conf_q <= '0;
            rd_vld_q  <= '0;
            rd_hit_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ack_q  <= s1_vld_q;
            wr_conf_q <= s1_vld_q & s1_conf_q;
            rd_vld_q  <= rd_s1_vld_q;
            rd_hit_q  <= rd_hit_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign wr_ack       = wr_ack_q;
    assign wr_conflict  = wr_conf_q;
    assign rd_out_valid = rd_vld_q;
    assign rd_hit       = rd_hit_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_xor_hash_table_mp.sv
// Scoreboard bench for xor_hash_table_mp on a 16-slot, 4-write/2-read configuration.
module tb_xor_hash_table_mp;
    import xor_hash_pkg::*;

    localparam int NW = 4;
    localparam int NR = 2;
    localparam int KW = 8;
    localparam int VW = 8;
    localparam int IW = 4;
    localparam int DW = KW + VW + 1;

    logic              clk;
    logic              reset;
    logic              in_ready;
    logic [NW-1:0]     wr_valid, wr_opt, wr_ack, wr_conflict;
    logic [NW*KW-1:0]  wr_key;
    logic [NW*VW-1:0]  wr_value;
    logic [NR-1:0]     rd_valid, rd_out_valid, rd_hit;
    logic [NR*KW-1:0]  rd_key;
    logic [NR*DW-1:0]  rd_data;

    xor_hash_table_mp #(
        .NUM_WR(NW), .NUM_RD(NR), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .INDEX_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset), .in_ready(in_ready),
        .wr_valid(wr_valid), .wr_opt(wr_opt), .wr_key(wr_key), .wr_value(wr_value),
        .wr_ack(wr_ack), .wr_conflict(wr_conflict),
        .rd_valid(rd_valid), .rd_key(rd_key),
        .rd_out_valid(rd_out_valid), .rd_hit(rd_hit), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int port; bit conf; int due; } wexp_t;
    typedef struct { int port; bit hit; logic [DW-1:0] data; int due; } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        int k;
        for (int w = 0; w < NW; w++) begin
            if (wr_ack[w]) begin
                k = -1;
                for (int i = 0; i < wq.size(); i++) if (k < 0 && wq[i].port == w) k = i;
                if (k < 0) begin
                    check($sformatf("wr_ack_unexpected_p%0d", w), 64'(wr_ack[w]), 64'd0);
                end else begin
                    check($sformatf("wr_conflict_p%0d", w), 64'(wr_conflict[w]), 64'(wq[k].conf));
                    check($sformatf("wr_ack_cycle_p%0d", w), 64'(cyc), 64'(wq[k].due));
                    wq.delete(k);
                end
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (rd_out_valid[r]) begin
                k = -1;
                for (int i = 0; i < rq.size(); i++) if (k < 0 && rq[i].port == r) k = i;
                if (k < 0) begin
                    check($sformatf("rd_valid_unexpected_p%0d", r), 64'(rd_out_valid[r]), 64'd0);
                end else begin
                    check($sformatf("rd_hit_p%0d", r), 64'(rd_hit[r]), 64'(rq[k].hit));
                    check($sformatf("rd_data_p%0d", r), 64'(rd_data[r*DW +: DW]), 64'(rq[k].data));
                    check($sformatf("rd_cycle_p%0d", r), 64'(cyc), 64'(rq[k].due));
                    rq.delete(k);
                end
            end
        end
    end

    task automatic put_wr(input int p, input logic op, input logic [KW-1:0] k,
                          input logic [VW-1:0] v, input bit conf, input bit exp_ack);
        wr_valid[p]          = 1'b1;
        wr_opt[p]            = op;
        wr_key[p*KW +: KW]   = k;
        wr_value[p*VW +: VW] = v;
        if (exp_ack) wq.push_back('{port: p, conf: conf, due: cyc + 2});
    endtask

    task automatic put_rd(input int p, input logic [KW-1:0] k, input bit hit,
                          input logic [DW-1:0] data);
        rd_valid[p]        = 1'b1;
        rd_key[p*KW +: KW] = k;
        rq.push_back('{port: p, hit: hit, data: data, due: cyc + 2});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_valid = '0;
            rd_valid = '0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},     64'(in_ready),     64'd0);
        check({tag, "_wr_ack"},       64'(wr_ack),       64'd0);
        check({tag, "_wr_conflict"},  64'(wr_conflict),  64'd0);
        check({tag, "_rd_out_valid"}, 64'(rd_out_valid), 64'd0);
        check({tag, "_rd_hit"},       64'(rd_hit),       64'd0);
        check({tag, "_rd_data"},      64'(rd_data),      64'd0);
    endtask

    // Optionally holds an unacceptable request during the first INIT cycles.
    task automatic wait_ready(input string tag, input bit poke);
        int k;
        k = 0;
        if (poke) begin
            put_wr(0, OPT_INSERT, 8'h05, 8'hAA, 1'b0, 1'b0);
            rd_valid[0]   = 1'b1;
            rd_key[7:0]   = 8'h05;
        end
        while (k < 100 && !in_ready) begin
            @(negedge clk);
            k++;
            if (k == 8) begin
                wr_valid = '0;
                rd_valid = '0;
            end
        end
        wr_valid = '0;
        rd_valid = '0;
        check({tag, "_init_cycles"}, 64'(k), 64'd16);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        reset    = 1'b0;
        wr_valid = '0;
        wr_opt   = '0;
        wr_key   = '0;
        wr_value = '0;
        rd_valid = '0;
        rd_key   = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        wait_ready("first", 1'b1);

        // Empty table: every lookup misses with zero data.
        put_rd(0, 8'h05, 1'b0, '0);
        put_rd(1, 8'h33, 1'b0, '0);
        step(1);

        // Basic insert then lookup.
        put_wr(0, OPT_INSERT, 8'h05, 8'h07, 1'b0, 1'b1);
        step(2);
        put_rd(0, 8'h05, 1'b1, 17'h10705);
        step(1);

        // Same-cycle conflict on index 5: port 0 wins, port 2 dropped.
        put_wr(0, OPT_INSERT, 8'h14, 8'h11, 1'b0, 1'b1);
        put_wr(2, OPT_INSERT, 8'h41, 8'h22, 1'b1, 1'b1);
        step(2);
        put_rd(0, 8'h14, 1'b1, 17'h11114);
        put_rd(1, 8'h41, 1'b0, '0);
        step(1);

        // Back-to-back writes from different ports to one index.
        put_wr(1, OPT_INSERT, 8'h27, 8'h33, 1'b0, 1'b1);
        step(1);
        put_wr(3, OPT_INSERT, 8'h50, 8'h44, 1'b0, 1'b1);
        step(2);
        put_rd(0, 8'h50, 1'b1, 17'h14450);
        put_rd(1, 8'h27, 1'b0, '0);
        step(1);
        put_wr(0, OPT_INSERT, 8'h05, 8'h55, 1'b0, 1'b1);
        step(2);
        put_rd(0, 8'h05, 1'b1, 17'h15505);
        put_rd(1, 8'h50, 1'b0, '0);
        step(1);

        // Insert then delete of the same key back-to-back on one port.
        put_wr(2, OPT_INSERT, 8'h41, 8'h66, 1'b0, 1'b1);
        step(1);
        put_wr(2, OPT_DELETE, 8'h41, 8'h00, 1'b0, 1'b1);
        step(2);
        put_rd(0, 8'h41, 1'b0, '0);
        put_rd(1, 8'h05, 1'b0, '0);
        step(1);

        // Lookup accepted on the edge the write to its slot commits.
        put_wr(2, OPT_INSERT, 8'h09, 8'h66, 1'b0, 1'b1);
        step(1);
`ifdef XOR_HASH_READ_BYPASS_EN
        put_rd(0, 8'h09, 1'b1, 17'h16609);
`else
        put_rd(0, 8'h09, 1'b0, '0);
`endif
        step(2);
        put_rd(1, 8'h09, 1'b1, 17'h16609);
        step(1);

        // Delete with a same-index but different key leaves the slot alone.
        put_wr(1, OPT_INSERT, 8'h05, 8'h55, 1'b0, 1'b1);
        step(2);
        put_wr(1, OPT_DELETE, 8'h14, 8'h00, 1'b0, 1'b1);
        step(2);
        put_rd(0, 8'h05, 1'b1, 17'h15505);
        put_rd(1, 8'h09, 1'b1, 17'h16609);
        step(1);
        put_wr(3, OPT_DELETE, 8'h05, 8'h00, 1'b0, 1'b1);
        step(2);
        put_rd(0, 8'h05, 1'b0, '0);
        step(1);

        // Reset in the middle of writes: no acks, INIT reruns, table empty.
        put_wr(0, OPT_INSERT, 8'h77, 8'h01, 1'b0, 1'b0);
        put_wr(1, OPT_INSERT, 8'h23, 8'h02, 1'b0, 1'b0);
        step(1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("midreset");
        reset = 1'b1;
        wait_ready("second", 1'b0);
        put_rd(0, 8'h09, 1'b0, '0);
        put_rd(1, 8'h77, 1'b0, '0);
        step(1);
        put_rd(0, 8'h50, 1'b0, '0);
        put_rd(1, 8'h23, 1'b0, '0);
        step(4);

        check("wr_scoreboard_drained", 64'(wq.size()), 64'd0);
        check("rd_scoreboard_drained", 64'(rq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
